// File: rtl/read_channel_scheduler_pkg.sv
// rtl/read_channel_scheduler_pkg.sv - shared types and widths for the read channel scheduler
package read_channel_scheduler_pkg;

  localparam int ADDR_WIDTH       = 26;
  localparam int DATA_WIDTH       = 32;
  localparam int ID_WIDTH         = 4;
  localparam int MAX_READ_MASTERS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } sched_state_t;

endpackage

// File: rtl/read_channel_scheduler_rr_priority_picker.sv
// rtl/read_channel_scheduler_rr_priority_picker.sv - rotating priority encoder, first request at or after ptr
module rr_priority_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             any_req
);

  always_comb begin : pick
    int               idx;
    logic [IDX_W-1:0] sel;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    sel     = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      sel = IDX_W'(idx);
      if (!any_req && req[sel]) begin
        any_req = 1'b1;
        grant   = sel;
      end
    end
  end

endmodule

// File: rtl/read_channel_scheduler.sv
// rtl/read_channel_scheduler.sv - round-robin sharing of one AXI AR/R channel pair, one burst in flight
module read_channel_scheduler
  import read_channel_scheduler_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*4-1:0]          m_arlen,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  output logic                              m_rlast,
  output logic [DATA_WIDTH-1:0]             m_rdata,
  output logic                              ARVALID,
  input  logic                              ARREADY,
  output logic [ID_WIDTH-1:0]               ARID,
  output logic [3:0]                        ARLEN,
  output logic [ADDR_WIDTH-1:0]             ARADDR,
  input  logic                              RVALID,
  input  logic                              RLAST,
  input  logic [ID_WIDTH-1:0]               RID,
  input  logic [DATA_WIDTH-1:0]             RDATA,
  output logic                              RREADY,
  output logic                              err_id
);

  sched_state_t            state, state_next;
  logic [IDX_W-1:0]        owner, rr_ptr, pick_idx;
  logic                    any_req;
  logic [3:0]              beat_cnt, len_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_arr [NUM_MASTERS];
  logic [3:0]              len_arr  [NUM_MASTERS];
  logic                    beat_bad;
  logic [IDX_W-1:0]        owner_inc;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_slice
    assign addr_arr[g] = m_araddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_arr[g]  = m_arlen[g*4 +: 4];
  end

  rr_priority_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (m_arvalid),
    .ptr     (rr_ptr),
    .grant   (pick_idx),
    .any_req (any_req)
  );

  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARID    = ID_WIDTH'(owner);
  assign m_rdata = RDATA;
  assign m_rlast = RLAST;

  // A beat is malformed if it carries a foreign ID or RLAST disagrees with the granted length.
  assign beat_bad  = (RID != ID_WIDTH'(owner)) ||
                     (RLAST && (beat_cnt != len_q)) ||
                     (!RLAST && (beat_cnt == len_q));
  assign owner_inc = (int'(owner) == NUM_MASTERS - 1) ? '0 : owner + 1'b1;

  always_comb begin
    state_next = state;
    m_arready  = '0;
    m_rvalid   = '0;
    ARVALID    = 1'b0;
    RREADY     = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && rst_n) begin
          m_arready[pick_idx] = 1'b1;
          state_next          = ADDR;
        end
      end
      ADDR: begin
        ARVALID = 1'b1;
        if (ARREADY) state_next = DATA;
      end
      DATA: begin
        RREADY          = 1'b1;
        m_rvalid[owner] = RVALID;
        if (RVALID && RLAST) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      err_id   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= pick_idx;
            addr_q <= addr_arr[pick_idx];
            len_q  <= len_arr[pick_idx];
          end
          if (RVALID) err_id <= 1'b1;
        end
        ADDR: begin
          if (ARREADY) beat_cnt <= '0;
          if (RVALID) err_id <= 1'b1;
        end
        DATA: begin
          if (RVALID) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_bad) err_id <= 1'b1;
            if (RLAST) rr_ptr <= owner_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_read_channel_scheduler.sv
// tb/tb_read_channel_scheduler.sv - directed scoreboard bench for read_channel_scheduler
module tb_read_channel_scheduler;
  import read_channel_scheduler_pkg::*;

  localparam int NM = 3;

  typedef struct {
    int                    id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [3:0]            len;
  } ar_t;

  typedef struct {
    logic [NM-1:0]         rv;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NM-1:0]            m_arvalid, m_arready, m_rvalid;
  logic [NM*ADDR_WIDTH-1:0] m_araddr;
  logic [NM*4-1:0]          m_arlen;
  logic                     m_rlast;
  logic [DATA_WIDTH-1:0]    m_rdata;
  logic                     ARVALID, ARREADY, RVALID, RLAST, RREADY, err_id;
  logic [ID_WIDTH-1:0]      ARID, RID;
  logic [3:0]               ARLEN;
  logic [ADDR_WIDTH-1:0]    ARADDR;
  logic [DATA_WIDTH-1:0]    RDATA;

  logic                     s_arvalid, s_rready, s_rlast, s_err;
  logic [NM-1:0]            s_arready, s_rvalid;
  logic [ID_WIDTH-1:0]      s_arid;
  logic [3:0]               s_arlen;
  logic [ADDR_WIDTH-1:0]    s_araddr;
  logic [DATA_WIDTH-1:0]    s_rdata;

  logic [ADDR_WIDTH-1:0]    req_addr [NM];
  logic [3:0]               req_len  [NM];
  ar_t                      exp_ar[$];
  beat_t                    exp_beat[$];
  int                       cur_owner;
  int                       errors = 0;
  int                       checks = 0;
  int                       lat;

  always #5 clk = ~clk;

  read_channel_scheduler #(.NUM_MASTERS(NM), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
    .m_rvalid(m_rvalid), .m_rlast(m_rlast), .m_rdata(m_rdata),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RDATA(RDATA), .RREADY(RREADY),
    .err_id(err_id)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Snapshot outputs mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_arvalid = ARVALID;  s_arready = m_arready; s_arid  = ARID;    s_arlen = ARLEN;
    s_araddr  = ARADDR;   s_rready  = RREADY;    s_rvalid = m_rvalid;
    s_rlast   = m_rlast;  s_rdata   = m_rdata;   s_err   = err_id;
    @(posedge clk);
    #1;
    for (int i = 0; i < NM; i++) if (s_arready[i]) m_arvalid[i] = 1'b0;
  endtask

  task automatic request(input int i, input logic [ADDR_WIDTH-1:0] a, input logic [3:0] l);
    req_addr[i] = a;
    req_len[i]  = l;
    m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
    m_arlen[i*4 +: 4] = l;
    m_arvalid[i] = 1'b1;
  endtask

  task automatic expect_grant(input int i);
    ar_t e;
    e.id = i; e.addr = req_addr[i]; e.len = req_len[i];
    exp_ar.push_back(e);
  endtask

  task automatic await_ar(input int ard, output int n);
    ar_t e;
    bit  ok = 0;
    bit  stable = 1;
    n = 0;
    while (n < 40 && !ok) begin
      tick();
      n++;
      if (s_arvalid) ok = 1;
    end
    chk("ar_timeout", ok, 1);
    if (!ok) return;
    if (exp_ar.size() == 0) begin
      chk("ar_unexpected", 0, 1);
      return;
    end
    e = exp_ar.pop_front();
    cur_owner = e.id;
    chk("arid", s_arid, e.id);
    chk("araddr", s_araddr, e.addr);
    chk("arlen", s_arlen, e.len);
    repeat (ard) begin
      tick();
      if (!(s_arvalid && s_arid == e.id && s_araddr == e.addr && s_arlen == e.len)) stable = 0;
    end
    if (ard > 0) chk("ar_stable", stable, 1);
    ARREADY = 1'b1;
    tick();
    ARREADY = 1'b0;
    tick();
    chk("ar_single_handshake", s_arvalid, 0);
    chk("rready_in_data", s_rready, 1);
  endtask

  task automatic do_beat(input int gap, input bit last, input logic [ID_WIDTH-1:0] rid);
    beat_t b;
    bit    quiet = 1;
    repeat (gap) begin
      tick();
      if (s_rvalid !== '0 || s_rready !== 1'b1) quiet = 0;
    end
    if (gap > 0) chk("gap_quiet", quiet, 1);
    RVALID = 1'b1; RDATA = $urandom; RLAST = last; RID = rid;
    b.rv = NM'(1 << cur_owner); b.data = RDATA; b.last = last;
    exp_beat.push_back(b);
    tick();
    b = exp_beat.pop_front();
    chk("m_rvalid", s_rvalid, b.rv);
    chk("m_rdata", s_rdata, b.data);
    chk("m_rlast", s_rlast, b.last);
    RVALID = 1'b0; RLAST = 1'b0;
  endtask

  task automatic serve(input int nbeats, input int gap, input logic [ID_WIDTH-1:0] rid);
    for (int b = 0; b < nbeats; b++) do_beat(gap, b == nbeats - 1, rid);
  endtask

  task automatic check_err(input string tag, input logic expv);
    tick();
    chk(tag, s_err, expv);
  endtask

  initial begin
    rst_n = 1'b0; m_arvalid = '1; m_araddr = '0; m_arlen = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0;
    tick();
    tick();
    chk("rst_arvalid", s_arvalid, 0);
    chk("rst_rready", s_rready, 0);
    chk("rst_m_rvalid", s_rvalid, 0);
    chk("rst_m_arready", s_arready, 0);
    chk("rst_err", s_err, 0);
    m_arvalid = '0;
    rst_n = 1'b1;

    // single request: grant latency, routing, last beat
    request(0, 26'h100, 4'd3); expect_grant(0);
    await_ar(0, lat); chk("latency_single", lat, 2);
    serve(4, 0, 4'd0);

    request(2, 26'h2a0, 4'd1); expect_grant(2);
    await_ar(5, lat); serve(2, 0, 4'd2);

    // contention from rr_ptr=0, one burst with gapped beats
    request(0, 26'h300, 4'd1); request(1, 26'h340, 4'd0); request(2, 26'h380, 4'd2);
    expect_grant(0); expect_grant(1); expect_grant(2);
    await_ar(0, lat); serve(2, 0, 4'd0);
    await_ar(0, lat); chk("latency_back_to_back", lat, 2); serve(1, 0, 4'd1);
    await_ar(0, lat); serve(3, 3, 4'd2);
    check_err("err_clean", 1'b0);

    request(1, 26'h400, 4'd0); expect_grant(1);
    await_ar(0, lat); serve(1, 0, 4'd1);

    // contention from rr_ptr=2
    request(0, 26'h500, 4'd0); request(1, 26'h540, 4'd1); request(2, 26'h580, 4'd0);
    expect_grant(2); expect_grant(0); expect_grant(1);
    await_ar(0, lat); serve(1, 0, 4'd2);
    await_ar(1, lat); serve(1, 0, 4'd0);
    await_ar(0, lat); serve(2, 1, 4'd1);
    check_err("err_clean2", 1'b0);

    // wrong RID, then a clean burst: error stays set
    request(1, 26'h600, 4'd2); expect_grant(1);
    await_ar(0, lat); serve(3, 0, 4'd2);
    check_err("err_rid", 1'b1);
    request(0, 26'h640, 4'd0); expect_grant(0);
    await_ar(0, lat); serve(1, 0, 4'd0);
    check_err("err_sticky", 1'b1);

    // asynchronous reset in the middle of beat 2
    request(1, 26'h700, 4'd3); expect_grant(1);
    await_ar(0, lat); do_beat(0, 1'b0, 4'd1);
    RVALID = 1'b1; RDATA = 32'hdead_beef; RID = 4'd1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_arvalid", ARVALID, 0);
    chk("async_rready", RREADY, 0);
    chk("async_m_rvalid", m_rvalid, 0);
    RVALID = 1'b0; m_arvalid = '0;
    tick();
    chk("async_err_cleared", s_err, 0);
    tick();
    rst_n = 1'b1;
    request(0, 26'h800, 4'd1); request(2, 26'h840, 4'd0);
    expect_grant(0); expect_grant(2);
    await_ar(0, lat); serve(2, 0, 4'd0);
    await_ar(0, lat); serve(1, 0, 4'd2);
    check_err("err_after_reset", 1'b0);

    // early RLAST: error, FSM still returns to idle and serves the next request
    request(0, 26'h900, 4'd3); expect_grant(0);
    await_ar(0, lat); serve(2, 0, 4'd0);
    tick();
    chk("err_early_last", s_err, 1);
    chk("idle_after_early_last", s_rready, 0);
    request(1, 26'h940, 4'd0); expect_grant(1);
    await_ar(0, lat); serve(1, 0, 4'd1);
    chk("ar_queue_drained", exp_ar.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/read_channel_scheduler.md
Name: read_channel_scheduler

Overview:
- Shares the single AXI read address/data channel pair between NUM_MASTERS read requesters: i-cache, d-cache, i-stream buffer.
- Round-robin arbitration; exactly one burst in flight at a time.
- Sits between the cache-side read ports and the core's top-level AR/R pins, in parallel with the write path.
- Tags every burst with the granted master index as ARID and routes returning R beats only to the owner.

Parameters:
- NUM_MASTERS, 3, number of read requesters (1..4).
- IDX_W, 2, width of the master index; must satisfy 2**IDX_W >= NUM_MASTERS.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- m_arvalid  input  NUM_MASTERS  per-master read request valid.
- m_arready  output  NUM_MASTERS  per-master request accepted.
- m_araddr  input  NUM_MASTERS*`ADDR_WIDTH  per-master byte address, packed with master 0 in the LSBs.
- m_arlen  input  NUM_MASTERS*4  per-master burst length minus 1.
- m_rvalid  output  NUM_MASTERS  per-master read beat valid.
- m_rlast  output  1  last beat of the burst; broadcast, meaningful only with m_rvalid.
- m_rdata  output  `DATA_WIDTH  read data; broadcast to all masters.
- ARVALID  output  1  AXI read address valid.
- ARREADY  input  1  AXI read address ready.
- ARID  output  4  zero-extended owner index.
- ARLEN  output  4  burst length minus 1.
- ARADDR  output  `ADDR_WIDTH  burst start address.
- RVALID  input  1  AXI read data valid.
- RLAST  input  1  AXI last beat.
- RID  input  4  AXI read ID.
- RDATA  input  `DATA_WIDTH  AXI read data.
- RREADY  output  1  AXI read data ready.
- err_id  output  1  sticky: RID mismatch or beat-count violation.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Reset state is IDLE.
- Registers and their reset values:
  - owner <= 0, rr_ptr <= 0, beat_cnt <= 0, len_q <= 0, addr_q <= 0, err_id <= 0.
- IDLE:
  - Select the first m_arvalid bit at or after rr_ptr, searching upward and wrapping.
  - If any request is present: latch owner, addr_q, len_q. Pulse m_arready[owner] for exactly that cycle. Go to ADDR next cycle.
  - Masters must hold arvalid/addr/len until arready, and must drop arvalid the cycle after arready.
- ADDR:
  - ARVALID=1; ARADDR=addr_q, ARLEN=len_q, ARID=owner, all held stable until ARREADY.
  - On ARVALID&&ARREADY: clear beat_cnt, go to DATA.
- DATA:
  - RREADY=1. m_rvalid[owner]=RVALID; all other m_rvalid bits 0.
  - m_rdata=RDATA and m_rlast=RLAST, combinational pass-through with zero latency.
  - Each RVALID beat increments beat_cnt (4-bit, no wrap needed since len<=15).
  - On RVALID&&RLAST: rr_ptr <= owner+1, wrapping to 0 at NUM_MASTERS; go to IDLE.
- Outputs outside the states above: ARVALID=0, RREADY=0, m_rvalid=0, m_arready=0. This covers reset and IDLE with no request.
- Error checks in DATA, on any beat:
  - RID!=owner sets err_id.
  - RLAST with beat_cnt!=len_q sets err_id.
  - beat_cnt==len_q with !RLAST sets err_id.
  - Data is still routed to owner; the FSM still exits only on RLAST.
- Latency: request seen in IDLE -> ARVALID two cycles later (IDLE grant cycle, then ADDR). RLAST beat -> new grant possible on the following cycle.
- Simultaneous requests: only one grant per IDLE cycle; the others wait, never starve (round-robin bound is NUM_MASTERS bursts).
- An RVALID arriving in IDLE/ADDR is not accepted (RREADY=0) and sets err_id.
- Reset mid-burst: returns immediately to IDLE. The outstanding burst is abandoned; slave/testbench must also be reset.
- m_arvalid bits at index >= NUM_MASTERS do not exist; the packed-bus slices are indexed by generate loop.

Decomposition:
- Shared package (mips_core_pkg or the mips_core.svh defines):
  - enum sched_state_t {IDLE, ADDR, DATA}.
  - Reuse `ADDR_WIDTH/`DATA_WIDTH.
  - Constant MAX_READ_MASTERS=4.
- One natural sub-module: rr_priority_picker. Inputs req vector and rr_ptr; outputs grant index and any_req. Purely combinational rotate-and-priority-encode, reusable by the write side.

Test Plan:
- Single request: m_arvalid=3'b001, addr 26'h100, len 3 -> ARVALID two cycles later with ARID=0, ARLEN=3; 4 beats routed to m_rvalid[0] only; m_rlast on 4th; rr_ptr=1.
- Contention: all three request at once with rr_ptr=0 -> bursts granted in order 0,1,2. Repeat with rr_ptr=2 -> order 2,0,1.
- ARREADY back-pressure: ARREADY low for 5 cycles -> ARVALID/ARADDR/ARID stable throughout; exactly one handshake.
- RVALID gaps: beats with 3-cycle gaps -> m_rvalid mirrors RVALID; FSM stays in DATA until RLAST; no err_id.
- Errors: RID=2 while owner=1 -> err_id=1 and sticky. Separately, RLAST on beat 2 of len 3 -> err_id=1 and FSM returns to IDLE.
- Async reset during DATA beat 2 -> outputs zero without waiting for a clock edge; post-reset request granted normally starting at rr_ptr=0.
